i2c_to_wb_sequencer: RTL and testbench

I2C_TO_WB_SEQUENCER -- requirements
Module: i2c_to_wb_sequencer

---
 rtl/i2c_to_wb_sequencer_if.sv | 25 ++
 rtl/i2c_to_wb_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_i2c_to_wb_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_to_wb_sequencer_if.sv
// Wishbone master bus between the I2C register sequencer and its target.
// Single 32-bit data path with byte-lane selects.
interface i2c_to_wb_sequencer_if #(
   parameter int AW = 32
);
   logic [AW-1:0] addr;
   logic [31:0]   data_w;
   logic [31:0]   data_r;
   logic [3:0]    sel;
   logic          we;
   logic          cyc;
   logic          stb;
   logic          ack;
   logic          err;

   modport master (
      output addr, data_w, sel, we, cyc, stb,
      input  data_r, ack, err
   );

   modport slave (
      input  addr, data_w, sel, we, cyc, stb,
      output data_r, ack, err
   );
endinterface

// File: rtl/i2c_to_wb_sequencer.sv
// Byte-level I2C slave sequencer: address match, register pointer, and
// single-byte Wishbone writes/reads with clock stretching and a bus timeout.
module i2c_to_wb_sequencer #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         AW         = 32,
   parameter int         TIMEOUT    = 255
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_ni,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       rx_valid_i,
   input  logic [7:0] rx_byte_i,
   input  logic       tx_req_i,
   output logic       busy_o,
   output logic       ack_o,
   output logic [7:0] tx_byte_o,
   i2c_to_wb_sequencer_if.master wb
);

   typedef enum logic [2:0] {
      IDLE, ADDR, PTR, WDATA, WB_WR, RD_WAIT, WB_RD, IGNORE
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        busy_d, ack_d;
   logic [7:0]  tx_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [5:0]  word_q, word_d;
   logic [7:0]  wdat_q, wdat_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        taken;

   assign wb.cyc    = cyc_q;
   assign wb.stb    = cyc_q;
   assign wb.we     = we_q;
   assign wb.sel    = sel_q;
   assign wb.addr   = AW'({word_q, 2'b00});
   assign wb.data_w = {4{wdat_q}};

   always_comb begin
      // NOTE: every value written here gets a default first, so no latch is inferred.
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = 1'b0;
      ack_d   = ack_o;
      tx_d    = tx_byte_o;
      cyc_d   = cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      word_d  = word_q;
      wdat_d  = wdat_q;
      cnt_d   = cnt_q;
      taken   = 1'b0;

      if (start_i) begin
         state_d = ADDR;
         cyc_d   = 1'b0;
         we_d    = 1'b0;
      end else if (stop_i) begin
         state_d = IDLE;
         cyc_d   = 1'b0;
         we_d    = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (rx_valid_i) begin
               taken  = 1'b1;
               busy_d = 1'b1;
               if (rx_byte_i[7:1] == SLAVE_ADDR) begin
                  ack_d   = 1'b1;
                  state_d = rx_byte_i[0] ? RD_WAIT : PTR;
               end else begin
                  ack_d   = 1'b0;
                  state_d = IGNORE;
               end
            end
            PTR: if (rx_valid_i) begin
               taken   = 1'b1;
               busy_d  = 1'b1;
               ptr_d   = rx_byte_i;
               ack_d   = 1'b1;
               state_d = WDATA;
            end
            WDATA: if (rx_valid_i) begin
               taken   = 1'b1;
               busy_d  = 1'b1;
               wdat_d  = rx_byte_i;
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               sel_d   = 4'b0001 << ptr_q[1:0];
               word_d  = ptr_q[7:2];
               cnt_d   = '0;
               state_d = WB_WR;
            end
            RD_WAIT: if (tx_req_i) begin
               taken   = 1'b1;
               busy_d  = 1'b1;
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               sel_d   = 4'b0001 << ptr_q[1:0];
               word_d  = ptr_q[7:2];
               cnt_d   = '0;
               state_d = WB_RD;
            end
            WB_WR, WB_RD: begin
               // SCL stays stretched while the bus cycle is open; ack beats err.
               taken  = 1'b1;
               busy_d = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               if (wb.ack) begin
                  cyc_d  = 1'b0;
                  we_d   = 1'b0;
                  busy_d = 1'b0;
                  ptr_d  = ptr_q + 8'd1;
                  if (state_q == WB_WR) begin
                     ack_d   = 1'b1;
                     state_d = WDATA;
                  end else begin
                     tx_d    = wb.data_r[{ptr_q[1:0], 3'b000} +: 8];
                     state_d = RD_WAIT;
                  end
               end else if (wb.err || cnt_q == TMO_LAST) begin
                  cyc_d  = 1'b0;
                  we_d   = 1'b0;
                  busy_d = 1'b0;
                  if (state_q == WB_WR) begin
                     ack_d   = 1'b0;
                     state_d = IGNORE;
                  end else begin
                     tx_d    = 8'hFF;
                     state_d = RD_WAIT;
                  end
               end
            end
            default: ;
         endcase

         // Bytes or read requests nobody consumes get NACK / 0xFF and a short stretch.
         if (!taken) begin
            if (rx_valid_i) begin
               busy_d = 1'b1;
               ack_d  = 1'b0;
            end
            if (tx_req_i) begin
               busy_d = 1'b1;
               tx_d   = 8'hFF;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= IDLE;
         ptr_q     <= 8'h00;
         busy_o    <= 1'b0;
         ack_o     <= 1'b0;
         tx_byte_o <= 8'hFF;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 4'h0;
         word_q    <= '0;
         wdat_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         busy_o    <= busy_d;
         ack_o     <= ack_d;
         tx_byte_o <= tx_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         word_q    <= word_d;
         wdat_q    <= wdat_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_i2c_to_wb_sequencer.sv
// Directed bench for i2c_to_wb_sequencer: writes, reads, address mismatch,
// bus timeout/error, pointer wrap, START/STOP priority and async reset.
module tb_i2c_to_wb_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       tx_req = 1'b0;
   logic       busy;
   logic       ack;
   logic [7:0] tx_byte;

   int errors = 0;
   int checks = 0;

   // Slave model: responds on the lat-th cycle of an open bus cycle (0 = never).
   int   lat = 0;
   bit   use_err = 1'b0;
   int   scnt = 0;
   int   cyc_cnt = 0;

   i2c_to_wb_sequencer_if #(.AW(32)) wb ();

   i2c_to_wb_sequencer #(
      .SLAVE_ADDR(7'h50),
      .AW        (32),
      .TIMEOUT   (4)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .start_i   (start),
      .stop_i    (stop),
      .rx_valid_i(rx_valid),
      .rx_byte_i (rx_byte),
      .tx_req_i  (tx_req),
      .busy_o    (busy),
      .ack_o     (ack),
      .tx_byte_o (tx_byte),
      .wb        (wb.master)
   );

   always #5 clk = ~clk;

   initial begin
      wb.data_r = 32'h0;
      wb.ack    = 1'b0;
      wb.err    = 1'b0;
   end

   always @(negedge clk) begin
      if (wb.cyc && wb.stb) begin
         cyc_cnt++;
         scnt++;
         if (lat != 0 && scnt == lat) begin
            wb.ack = !use_err;
            wb.err = use_err;
         end else begin
            wb.ack = 1'b0;
            wb.err = 1'b0;
         end
      end else begin
         scnt   = 0;
         wb.ack = 1'b0;
         wb.err = 1'b0;
      end
   end

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_tx;
      tx_req = 1'b1;
      @(negedge clk);
      tx_req = 1'b0;
   endtask

   // Byte decided without bus traffic: busy for exactly one cycle, then ack.
   task automatic decide(input logic [7:0] b, input logic exp_ack, input string name);
      pulse_rx(b);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_pulse: got %b want 1", name, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack !== exp_ack) begin
         errors++;
         $display("FAIL %s decision: busy=%b ack=%b want busy=0 ack=%b", name, busy, ack, exp_ack);
      end
   endtask

   task automatic wait_release(input string name, output int n);
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: busy stuck at %b after %0d cycles, want 0", name, busy, n);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, ack, tx_byte} !== {1'b0, 1'b0, 8'hFF}) begin
         errors++;
         $display("FAIL reset_io: busy=%b ack=%b tx=%h want 0 0 ff", busy, ack, tx_byte);
      end
      checks++;
      if ({wb.cyc, wb.stb, wb.we, wb.sel} !== 7'b0 || wb.addr !== 32'h0 || wb.data_w !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%b addr=%h data=%h want all 0",
                  wb.cyc, wb.stb, wb.we, wb.sel, wb.addr, wb.data_w);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write;
      int n;
      pulse_start();
      decide(8'hA0, 1'b1, "wr_addr");
      decide(8'h05, 1'b1, "wr_ptr");
      lat = 2; use_err = 1'b0; cyc_cnt = 0;
      pulse_rx(8'h3C);
      checks++;
      if ({wb.cyc, wb.stb, wb.we, busy} !== 4'b1111 || wb.addr !== 32'h4 ||
          wb.sel !== 4'b0010 || wb.data_w !== 32'h3C3C3C3C) begin
         errors++;
         $display("FAIL wr_bus: cyc=%b stb=%b we=%b busy=%b addr=%h sel=%b data=%h want 1 1 1 1 4 0010 3c3c3c3c",
                  wb.cyc, wb.stb, wb.we, busy, wb.addr, wb.sel, wb.data_w);
      end
      wait_release("wr_data", n);
      checks++;
      if (n !== 2 || ack !== 1'b1 || wb.cyc !== 1'b0 || cyc_cnt !== 2) begin
         errors++;
         $display("FAIL wr_done: wait=%0d ack=%b cyc=%b cyc_cycles=%0d want 2 1 0 2", n, ack, wb.cyc, cyc_cnt);
      end
   endtask

   task automatic test_read;
      int n;
      pulse_start();
      decide(8'hA1, 1'b1, "rd_addr");
      wb.data_r = 32'hDDCCBBAA;
      pulse_tx();
      checks++;
      if ({wb.cyc, wb.stb, wb.we, busy} !== 4'b1101 || wb.addr !== 32'h4 || wb.sel !== 4'b0100) begin
         errors++;
         $display("FAIL rd_bus: cyc=%b stb=%b we=%b busy=%b addr=%h sel=%b want 1 1 0 1 4 0100",
                  wb.cyc, wb.stb, wb.we, busy, wb.addr, wb.sel);
      end
      wait_release("rd_data", n);
      checks++;
      if (n !== 2 || tx_byte !== 8'hCC || wb.cyc !== 1'b0) begin
         errors++;
         $display("FAIL rd_done: wait=%0d tx=%h cyc=%b want 2 cc 0", n, tx_byte, wb.cyc);
      end
      pulse_tx();
      checks++;
      if (wb.addr !== 32'h4 || wb.sel !== 4'b1000) begin
         errors++;
         $display("FAIL rd_ptr_inc: addr=%h sel=%b want 4 1000", wb.addr, wb.sel);
      end
      wait_release("rd_data2", n);
      checks++;
      if (tx_byte !== 8'hDD) begin
         errors++;
         $display("FAIL rd_lane3: tx=%h want dd", tx_byte);
      end
   endtask

   task automatic test_wrong_addr;
      pulse_start();
      decide(8'hA2, 1'b0, "bad_addr");
      cyc_cnt = 0;
      decide(8'h11, 1'b0, "ign_rx");
      pulse_tx();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL ign_tx_busy: got %b want 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx_byte !== 8'hFF || cyc_cnt !== 0) begin
         errors++;
         $display("FAIL ign_tx: busy=%b tx=%h cyc_cycles=%0d want 0 ff 0", busy, tx_byte, cyc_cnt);
      end
   endtask

   task automatic test_timeout;
      int n;
      pulse_start();
      decide(8'hA0, 1'b1, "to_addr");
      decide(8'h10, 1'b1, "to_ptr");
      lat = 0; cyc_cnt = 0;
      pulse_rx(8'h77);
      wait_release("to_wr", n);
      checks++;
      if (cyc_cnt !== 4 || n !== 4 || ack !== 1'b0) begin
         errors++;
         $display("FAIL to_wr: cyc_cycles=%0d wait=%0d ack=%b want 4 4 0", cyc_cnt, n, ack);
      end
      decide(8'h55, 1'b0, "to_ignore");
      checks++;
      if (cyc_cnt !== 4) begin
         errors++;
         $display("FAIL to_no_bus: cyc_cycles=%0d want 4", cyc_cnt);
      end

      pulse_start();
      decide(8'hA0, 1'b1, "err_addr");
      decide(8'h10, 1'b1, "err_ptr");
      lat = 2; use_err = 1'b1; cyc_cnt = 0;
      pulse_rx(8'h88);
      wait_release("err_wr", n);
      checks++;
      if (cyc_cnt !== 2 || ack !== 1'b0) begin
         errors++;
         $display("FAIL err_wr: cyc_cycles=%0d ack=%b want 2 0", cyc_cnt, ack);
      end
      decide(8'h55, 1'b0, "err_ignore");

      // Pointer still 0x10: good read, timed-out read, then read at 0x11.
      use_err = 1'b0;
      pulse_start();
      decide(8'hA1, 1'b1, "rto_addr");
      wb.data_r = 32'h44332211;
      lat = 2;
      pulse_tx();
      checks++;
      if (wb.addr !== 32'h10 || wb.sel !== 4'b0001) begin
         errors++;
         $display("FAIL ptr_kept: addr=%h sel=%b want 10 0001", wb.addr, wb.sel);
      end
      wait_release("rto_rd1", n);
      lat = 0;
      pulse_tx();
      wait_release("rto_rd2", n);
      checks++;
      if (tx_byte !== 8'hFF || n !== 4) begin
         errors++;
         $display("FAIL rd_timeout: tx=%h wait=%0d want ff 4", tx_byte, n);
      end
      lat = 2;
      pulse_tx();
      checks++;
      if (wb.sel !== 4'b0010) begin
         errors++;
         $display("FAIL rd_timeout_ptr: sel=%b want 0010", wb.sel);
      end
      wait_release("rto_rd3", n);
      checks++;
      if (tx_byte !== 8'h22) begin
         errors++;
         $display("FAIL rd_after_to: tx=%h want 22", tx_byte);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      pulse_start();
      decide(8'hA0, 1'b1, "wrap_addr");
      decide(8'hFF, 1'b1, "wrap_ptr");
      lat = 2; use_err = 1'b0;
      pulse_rx(8'h5A);
      checks++;
      if (wb.addr !== 32'hFC || wb.sel !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_ff: addr=%h sel=%b want fc 1000", wb.addr, wb.sel);
      end
      wait_release("wrap_w1", n);
      pulse_rx(8'h6B);
      checks++;
      if (wb.addr !== 32'h0 || wb.sel !== 4'b0001 || wb.data_w !== 32'h6B6B6B6B) begin
         errors++;
         $display("FAIL wrap_00: addr=%h sel=%b data=%h want 0 0001 6b6b6b6b", wb.addr, wb.sel, wb.data_w);
      end
      wait_release("wrap_w2", n);
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL wrap_ack: ack=%b want 1", ack);
      end

      // START while a read cycle is open.
      pulse_start();
      decide(8'hA1, 1'b1, "rs_addr");
      lat = 0;
      pulse_tx();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({wb.cyc, wb.stb, busy} !== 3'b000) begin
         errors++;
         $display("FAIL restart_drop: cyc=%b stb=%b busy=%b want 0 0 0", wb.cyc, wb.stb, busy);
      end
      decide(8'hA1, 1'b1, "rs_in_addr");
   endtask

   task automatic test_start_stop;
      pulse_start();
      decide(8'hA0, 1'b1, "ss_addr");
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      decide(8'hA0, 1'b0, "stop_idle");
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      decide(8'hA0, 1'b1, "start_wins");
   endtask

   task automatic test_reset_mid;
      int n;
      pulse_start();
      decide(8'hA0, 1'b1, "rm_addr");
      decide(8'h20, 1'b1, "rm_ptr");
      lat = 0;
      pulse_rx(8'h99);
      checks++;
      if (wb.cyc !== 1'b1) begin
         errors++;
         $display("FAIL rm_cyc_open: cyc=%b want 1", wb.cyc);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({wb.cyc, wb.stb, wb.we, busy, ack, tx_byte} !== {5'b00000, 8'hFF} ||
          wb.sel !== 4'h0 || wb.addr !== 32'h0 || wb.data_w !== 32'h0) begin
         errors++;
         $display("FAIL rm_async: cyc=%b stb=%b we=%b busy=%b ack=%b tx=%h sel=%b addr=%h data=%h want 0 0 0 0 0 ff 0 0 0",
                  wb.cyc, wb.stb, wb.we, busy, ack, tx_byte, wb.sel, wb.addr, wb.data_w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      decide(8'hA1, 1'b1, "rm_rd_addr");
      wb.data_r = 32'hAABBCCDD;
      lat = 2;
      pulse_tx();
      checks++;
      if (wb.addr !== 32'h0 || wb.sel !== 4'b0001) begin
         errors++;
         $display("FAIL rm_ptr_reset: addr=%h sel=%b want 0 0001", wb.addr, wb.sel);
      end
      wait_release("rm_rd", n);
      checks++;
      if (tx_byte !== 8'hDD) begin
         errors++;
         $display("FAIL rm_rd_data: tx=%h want dd", tx_byte);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wrong_addr();
      test_timeout();
      test_back_to_back();
      test_start_stop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
